// File: rtl/fp_mult_normalizer_if.sv
// Handshake and data bundle between the FP multiplier core, this normalizer and the result consumer.
// The slave modport is the normalizer's view; master is the driver/consumer view.
interface fp_mult_normalizer_if;
   logic        in_valid;
   logic        in_ready;
   logic        Signo_resul;
   logic [8:0]  Exp_resul;
   logic [47:0] Mant_producto;
   logic        Op_cero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Resultado;
   logic        Overflow;
   logic        Underflow;
   logic        Inexacto;

   modport master (
      output in_valid,
      output Signo_resul,
      output Exp_resul,
      output Mant_producto,
      output Op_cero,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  Resultado,
      input  Overflow,
      input  Underflow,
      input  Inexacto
   );

   modport slave (
      input  in_valid,
      input  Signo_resul,
      input  Exp_resul,
      input  Mant_producto,
      input  Op_cero,
      input  out_ready,
      output in_ready,
      output out_valid,
      output Resultado,
      output Overflow,
      output Underflow,
      output Inexacto
   );
endinterface

// File: rtl/fp_mult_normalizer.sv
// Two-stage bias removal, normalization, rounding and IEEE-754 packing for the FP multiplier.
// Define ROUND_NEAREST_EN for round-to-nearest-even; without it the mantissa is truncated.
module fp_mult_normalizer #(
   parameter int BIAS    = 127,
   parameter int EXP_MAX = 255
) (
   input logic                 clk,
   input logic                 rst_n,
   fp_mult_normalizer_if.slave bus
);

   typedef struct packed {
      logic              sign;
      logic              zero;
      logic signed [9:0] exp;
      logic [22:0]       mant;
      logic              guard;
      logic              sticky;
   } stage1_t;

   stage1_t           s1_d;
   stage1_t           s1_q;
   logic              v1;
   logic              v2;
   logic              s2_adv;
   logic              in_ready_int;
   logic              in_fire;
   logic              norm_shift;
   logic              round_up;
   logic [23:0]       mant_sum;
   logic signed [9:0] exp_rnd;
   logic [31:0]       res_d;
   logic [31:0]       res_q;
   logic              ovf_d;
   logic              ovf_q;
   logic              unf_d;
   logic              unf_q;
   logic              inx_d;
   logic              inx_q;

   // Stage 2 frees up whenever it is empty or its result is being taken this cycle.
   assign s2_adv       = !v2 || bus.out_ready;
   assign in_ready_int = !v1 || s2_adv;
   assign in_fire      = bus.in_valid && in_ready_int;

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = v2;
   assign bus.Resultado = res_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Underflow = unf_q;
   assign bus.Inexacto  = inx_q;

   // A product in [2,4) has its leading one at bit 47 and bumps the exponent by one.
   always_comb begin
      s1_d       = '0;
      norm_shift = bus.Mant_producto[47];
      s1_d.sign  = bus.Signo_resul;
      s1_d.zero  = bus.Op_cero;
      s1_d.exp   = signed'({1'b0, bus.Exp_resul}) - signed'(10'(BIAS))
                   + signed'({9'b0, norm_shift});
      if (norm_shift) begin
         s1_d.mant   = bus.Mant_producto[46:24];
         s1_d.guard  = bus.Mant_producto[23];
         s1_d.sticky = |bus.Mant_producto[22:0];
      end else begin
         s1_d.mant   = bus.Mant_producto[45:23];
         s1_d.guard  = bus.Mant_producto[22];
         s1_d.sticky = |bus.Mant_producto[21:0];
      end
   end

   // Stage 1 register: holds its entry until stage 2 can take it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         s1_q <= '0;
      end else begin
         if (in_fire) begin
            v1   <= 1'b1;
            s1_q <= s1_d;
         end else if (s2_adv) begin
            v1 <= 1'b0;
         end
      end
   end

   // Round, then classify on the post-carry exponent so a round-up into 255 saturates.
   always_comb begin
`ifdef ROUND_NEAREST_EN
      round_up = s1_q.guard && (s1_q.sticky || s1_q.mant[0]);
`else
      round_up = 1'b0;
`endif
      mant_sum = {1'b0, s1_q.mant} + {23'b0, round_up};
      exp_rnd  = s1_q.exp + signed'({9'b0, mant_sum[23]});
      res_d    = {s1_q.sign, exp_rnd[7:0], mant_sum[22:0]};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      inx_d    = s1_q.guard || s1_q.sticky;
      if (s1_q.zero) begin
         res_d = {s1_q.sign, 31'b0};
         inx_d = 1'b0;
      end else if (exp_rnd >= signed'(10'(EXP_MAX))) begin
         res_d = {s1_q.sign, 8'hFF, 23'b0};
         ovf_d = 1'b1;
         inx_d = 1'b1;
      end else if (exp_rnd <= 10'sd0) begin
         res_d = {s1_q.sign, 31'b0};
         unf_d = 1'b1;
         inx_d = 1'b1;
      end
   end

   // Stage 2 register: result and flags only change when the slot advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         res_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         inx_q <= 1'b0;
      end else if (s2_adv) begin
         v2 <= v1;
         if (v1) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            inx_q <= inx_d;
         end
      end
   end

endmodule

// File: tb/tb_fp_mult_normalizer.sv
// Directed scoreboard bench for fp_mult_normalizer; expectations follow ROUND_NEAREST_EN when defined.
module tb_fp_mult_normalizer;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      logic        inx;
   } exp_t;

`ifdef ROUND_NEAREST_EN
   localparam logic [31:0] T3_RES    = 32'h3F800002;
   localparam logic [31:0] CARRY_RES = 32'h40000000;
   localparam logic [31:0] OVR_RES   = 32'h7F800000;
   localparam logic        OVR_FLAG  = 1'b1;
`else
   localparam logic [31:0] T3_RES    = 32'h3F800001;
   localparam logic [31:0] CARRY_RES = 32'h3FFFFFFF;
   localparam logic [31:0] OVR_RES   = 32'h7F7FFFFF;
   localparam logic        OVR_FLAG  = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   accepted;
   exp_t sb[$];

   fp_mult_normalizer_if bus ();

   fp_mult_normalizer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Drives one input and pushes its expected result on the cycle it is accepted.
   task automatic applyStimulus(input string tag, input logic sign, input logic [8:0] e,
                                input logic [47:0] m, input logic zero, input logic [31:0] res,
                                input logic ovf, input logic unf, input logic inx);
      exp_t item;
      bit   done;
      item.res = res;
      item.ovf = ovf;
      item.unf = unf;
      item.inx = inx;
      bus.Signo_resul   = sign;
      bus.Exp_resul     = e;
      bus.Mant_producto = m;
      bus.Op_cero       = zero;
      bus.in_valid      = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(item);
            accepted++;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      assert (done) else begin
         errors++;
         $error("[TB] FAIL %s accept: observed timeout expected in_ready", tag);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic waitDrain(input string tag);
      for (int c = 0; c < 50 && sb.size() != 0; c++) begin
         @(posedge clk);
         #1;
      end
      checkOutput({tag, " drained"}, 32'(sb.size()), 32'd0);
   endtask

   // Output side of the scoreboard: every completed output transfer pops one expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL unexpected output: observed %h expected none", bus.Resultado);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("Resultado", bus.Resultado, e.res);
            checkOutput("Overflow", 32'(bus.Overflow), 32'(e.ovf));
            checkOutput("Underflow", 32'(bus.Underflow), 32'(e.unf));
            checkOutput("Inexacto", 32'(bus.Inexacto), 32'(e.inx));
         end
      end
   end

   initial begin
      clk               = 1'b0;
      rst_n             = 1'b0;
      checks            = 0;
      errors            = 0;
      accepted          = 0;
      bus.in_valid      = 1'b0;
      bus.Signo_resul   = 1'b0;
      bus.Exp_resul     = '0;
      bus.Mant_producto = '0;
      bus.Op_cero       = 1'b0;
      bus.out_ready     = 1'b1;

      #12;
      checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset Resultado", bus.Resultado, 32'd0);
      checkOutput("reset flags", {29'b0, bus.Overflow, bus.Underflow, bus.Inexacto}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus("one", 1'b0, 9'd254, 48'h400000000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
      checkOutput("latency bubble", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("latency valid", 32'(bus.out_valid), 32'd1);
      waitDrain("one");

      applyStimulus("1.5sq", 1'b1, 9'd254, 48'h900000000000, 1'b0, 32'hC0100000, 1'b0, 1'b0, 1'b0);
      applyStimulus("round", 1'b0, 9'd254, 48'h400000C00000, 1'b0, T3_RES, 1'b0, 1'b0, 1'b1);
      applyStimulus("ovf", 1'b0, 9'd400, 48'h400000000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1);
      applyStimulus("unf", 1'b0, 9'd100, 48'h400000000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1);
      applyStimulus("zero", 1'b1, 9'd300, 48'h400000000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0);
      applyStimulus("carry", 1'b0, 9'd254, 48'h7FFFFFC00000, 1'b0, CARRY_RES, 1'b0, 1'b0, 1'b1);
      applyStimulus("maxnorm", 1'b0, 9'd381, 48'h400000000000, 1'b0, 32'h7F000000, 1'b0, 1'b0, 1'b0);
      applyStimulus("e255", 1'b1, 9'd382, 48'h400000000000, 1'b0, 32'hFF800000, 1'b1, 1'b0, 1'b1);
      applyStimulus("minnorm", 1'b0, 9'd128, 48'h400000000000, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0);
      applyStimulus("e0", 1'b1, 9'd127, 48'h400000000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
      applyStimulus("sticky", 1'b0, 9'd254, 48'h400000000001, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1);
      applyStimulus("rndovf", 1'b0, 9'd381, 48'h7FFFFFC00000, 1'b0, OVR_RES, OVR_FLAG, 1'b0, 1'b1);
      waitDrain("directed");

      // Stall: only two entries fit while the consumer refuses, and the head result must hold.
      bus.out_ready = 1'b0;
      accepted = 0;
      fork
         begin
            applyStimulus("bb0", 1'b0, 9'd254, 48'h400000000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
            applyStimulus("bb1", 1'b1, 9'd254, 48'h900000000000, 1'b0, 32'hC0100000, 1'b0, 1'b0, 1'b0);
            applyStimulus("bb2", 1'b0, 9'd128, 48'h400000000000, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0);
            applyStimulus("bb3", 1'b0, 9'd400, 48'h400000000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            checkOutput("stall head early", bus.Resultado, 32'h3F800000);
            repeat (2) @(posedge clk);
            #1;
            checkOutput("stall accepted", 32'(accepted), 32'd2);
            checkOutput("stall in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("stall out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall head held", bus.Resultado, sb[0].res);
            bus.out_ready = 1'b1;
         end
      join
      waitDrain("stall");
      checkOutput("stall total", 32'(accepted), 32'd4);

      // Reset with two entries in flight: both must vanish.
      bus.out_ready = 1'b0;
      applyStimulus("pre0", 1'b0, 9'd400, 48'h400000000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1);
      applyStimulus("pre1", 1'b1, 9'd254, 48'h900000000000, 1'b0, 32'hC0100000, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("midreset Resultado", bus.Resultado, 32'd0);
      checkOutput("midreset flags", {29'b0, bus.Overflow, bus.Underflow, bus.Inexacto}, 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("postreset idle", 32'(bus.out_valid), 32'd0);
      applyStimulus("post", 1'b1, 9'd300, 48'h400000000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0);
      waitDrain("post");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_mult_normalizer.md
Name: fp_mult_normalizer

Overview:
Downstream stage of the single-precision FP multiplier datapath. It consumes the 9-bit raw exponent sum, the 48-bit mantissa product and the result sign. It subtracts the bias, normalizes and rounds, detects overflow and underflow, and packs the IEEE-754 single-precision result. It is a 2-stage pipeline with valid/ready handshakes on both sides.

Parameters:
BIAS, 127, exponent bias subtracted from the raw exponent sum
EXP_MAX, 255, all-ones biased exponent (infinity encoding)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream data valid
in_ready  output  1  stage can accept input this cycle
Signo_resul  input  1  result sign (Sa xor Sb)
Exp_resul  input  9  raw exponent sum Ea+Eb, unsigned 0..510
Mant_producto  input  48  product of 24-bit mantissas with hidden 1s, value in [1,4)
Op_cero  input  1  either operand is zero
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
Resultado  output  32  packed {sign, exp[7:0], mant[22:0]}
Overflow  output  1  result saturated to infinity
Underflow  output  1  result flushed to zero
Inexacto  output  1  discarded bits were nonzero

Behaviour:
- Reset: asynchronous on rst_n low. Both stage valid bits clear. out_valid=0, Resultado=0, Overflow=0, Underflow=0, Inexacto=0. Reset asserted mid-operation drops all in-flight data.
- Handshake: a transfer occurs when valid && ready on a clock edge.
  - s2_adv = !v2 || out_ready
  - in_ready = !v1 || s2_adv, combinational
  - Outputs are held stable while out_valid && !out_ready.
  - Latency is 2 cycles from input accept to out_valid when out_ready is high. Throughput is 1 result per cycle.
- Stage 1 (normalize):
  - n = Mant_producto[47].
  - If n=1: m = P[46:24], guard = P[23], sticky = |P[22:0].
  - If n=0: m = P[45:23], guard = P[22], sticky = |P[21:0].
  - Compute E = Exp_resul - BIAS + n as a 10-bit signed value.
  - Register sign, E, m, guard, sticky and Op_cero.
- Stage 2 (round and pack):
  - Rounding uses lsb = m[0]: round_up = guard && (sticky || lsb). With the macro off, round_up = 0.
  - A rounding carry-out (m=all ones, round_up=1) sets m=0 and E=E+1.
  - Inexacto = guard || sticky.
- Stage 2 priority, first match wins:
  1. Op_cero: Resultado = {sign, 31'b0}, all flags 0.
  2. E >= EXP_MAX (checked after the carry): Resultado = {sign, 8'hFF, 23'b0}, Overflow=1, Inexacto=1.
  3. E <= 0: Resultado = {sign, 31'b0}, Underflow=1, Inexacto=1. No subnormal output.
  4. Otherwise: Resultado = {sign, E[7:0], m}.
- Flags are registered with Resultado and are only meaningful while out_valid=1.
- NaN and infinity operands are out of scope; the upstream special-case logic bypasses this block for them.

Optional Feature:
ROUND_NEAREST_EN
- Defined: round-to-nearest-even as described above, including the carry into the exponent.
- Undefined: truncation; the round_up logic is removed. Inexacto is still reported, and overflow/underflow are evaluated on the unrounded E.

Test Plan:
1. Exp_resul=254, Mant_producto=48'h400000000000 (1.0*1.0), out_ready=1 -> 2 cycles later out_valid=1, Resultado=32'h3F800000, all flags 0.
2. Exp_resul=254, Mant_producto=48'h900000000000 (1.5*1.5), Signo_resul=1 -> Resultado=32'hC0100000, Inexacto=0.
3. Exp_resul=254, Mant_producto=48'h400000C00000 -> with ROUND_NEAREST_EN: Resultado=32'h3F800002, Inexacto=1. Without it: Resultado=32'h3F800001, Inexacto=1.
4. Exp_resul=400, Mant_producto=48'h400000000000 -> Resultado=32'h7F800000, Overflow=1. Then Exp_resul=100 -> Resultado=32'h00000000, Underflow=1.
5. Op_cero=1, Signo_resul=1, Exp_resul=300 -> Resultado=32'h80000000, all flags 0.
6. Send 4 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, Resultado held stable. Release out_ready -> all 4 results arrive in order, no loss or duplicates. Pulse rst_n low mid-stream -> out_valid=0 immediately and no stale output after release.
